sha256_padder: RTL
==================

# sha256_padder

Message front end for the SHA-256 compression core. It takes a byte-aligned message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and the 64-bit bit length. It packs the result into 512-bit blocks, drives the core's `start`/`done` handshake block by block, and re-initialises the core before each message. It signals when the core's 256-bit output holds the final digest.

## Interface
- `LEN_W`, default 64: width of the message bit-length counter. Values below 64 are zero-extended into the length field.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: padder accepts a word when this and `in_valid` are both high.
- `in_data` in 32: message word. The first message byte is in [31:24].
- `in_last` in 1: this word is the final word of the message.
- `in_bytes` in 2: number of valid bytes in the last word. 0 means 4; values 1–3 are literal. Ignored unless `in_last` is high.
- `blk_data` out 512: block to the core. Word i sits at [32*i +: 32].
- `core_start` out 1: one-cycle pulse that starts a block.
- `core_done` in 1: core block-complete pulse.
- `core_init` out 1: one-cycle pulse, wired to the core's synchronous reset, that loads H0..H7.
- `msg_done` out 1: one-cycle pulse; the core digest is valid in this cycle.
- `busy` out 1: high from message acceptance until `msg_done`.

## Operation
- States: `INIT`, `FILL`, `PAD`, `LEN`, `ISSUE`, `WAIT`, `FIN`.
- **INIT:** entered on the first accepted word of a new message, or directly from reset idle when `in_valid` rises.
  - Pulses `core_init` for one cycle and clears the bit counter.
  - Goes to `FILL`. The word is not consumed in `INIT`.
- **FILL:**
  - `in_ready`=1. Each accepted word is written to buffer word `idx`, `idx`++, and the bit counter += 32.
  - On the last word, k = `in_bytes` (0 maps to 4). Bytes beyond k are zeroed. If k<4, byte k = 0x80 and the counter += 8k.
  - If k=4, a 0x80000000 word is still owed. This goes to `PAD` with a `marker_pending` flag.
  - A non-last word that completes the buffer (`idx`=16) goes to `ISSUE`.
- **PAD:**
  - Writes one word per cycle: first the marker if pending, then zeros.
  - Continues until `idx`=14, then goes to `LEN`.
  - If the buffer fills (`idx`=16) before reaching 14, it goes to `ISSUE` with `need_len_block`=1. The next block is then all zeros plus the length.
- **LEN:** words 14/15 = counter[63:32]/[31:0]. Goes to `ISSUE` with `final`=1.
- **ISSUE:** `core_start`=1 for exactly one cycle. Goes to `WAIT`.
- **WAIT:**
  - `blk_data` must be held stable until `core_done`.
  - On `core_done`: clear the buffer and set `idx`=0.
  - If `final`: go to `FIN`.
  - Else if `need_len_block`: go to `PAD`.
  - Else: go to `FILL`.
- **FIN:** `msg_done`=1 for one cycle, then the block returns to idle `FILL` with `busy`=0. The next word starts via `INIT`.
- **Arithmetic:** the counter wraps modulo 2^`LEN_W`; there is no overflow flag.
- **Unsupported input:** zero-length messages are unsupported, since `in_last` always carries at least 1 byte.

## Timing
- **Reset values:** `in_ready`=0, `core_start`=0, `core_init`=0, `msg_done`=0, `busy`=0, `blk_data`=0.
  - State after reset is idle `FILL` with the new-message flag set.
  - `in_ready` goes high on the first clock edge after `reset` deasserts.
- **Throughput:** 1 word/cycle in `FILL`. `in_ready`=0 in all other states.
- **Latency after `in_last` accept:**
  - The `PAD` phase takes (14 − `idx`) cycles, or runs to 16 then restarts on the extra block.
  - `LEN` takes 1 cycle, then `ISSUE` follows on the next cycle.
- **Core data contract:** the core reads words 0..15 on the 16 cycles following `start`. `blk_data` must not change between `ISSUE` and `core_done`.
- **`msg_done` timing:** asserts the cycle after the final `core_done`, which is when the core's output register has accumulated.
- **Ignored `core_done`:** a `core_done` pulse outside `WAIT` is ignored.
- **Mid-message reset:** `reset` asserted mid-message aborts immediately, with no `msg_done`. All outputs return to their reset values asynchronously.

## Structure
- Shared package `sha256_pkg`:
  - `padder_state_t` enum.
  - `BLOCK_WORDS`=16, `LEN_WORD_IDX`=14, `PAD_MARKER`=8'h80.
  - The `SHA256_H0..H7` constants move here from the include file.
- No sub-module is needed. The buffer, counter and FSM live in one module.

## Test plan
- **"abc":** `in_data`=0x61626300, `in_bytes`=3, `in_last`=1.
  - Expect one `core_start`, with `blk_data` word0=0x61626380, words1–14=0 and word15=0x18.
  - Expect `msg_done` with digest ba7816bf…f20015ad.
- **"abcd":** `in_bytes`=0, `in_last`=1.
  - Expect word0=0x61626364, word1=0x80000000, word15=0x20, and a single block.
- **56-byte message:** 14 full words, last with `in_bytes`=0.
  - Expect block0 words 14=0x80000000 and 15=0.
  - Expect block1 all zero except word15=0x1C0.
  - Expect two `core_start` pulses and one `msg_done`.
- **64-byte message:**
  - Expect block1 word0=0x80000000, word15=0x200.
  - Expect `busy` high throughout and `core_init` pulsed once.
- **Backpressure and spurious done:**
  - Hold `in_valid`=1 through `WAIT`: `in_ready`=0 and no word is lost or duplicated.
  - Inject `core_done` during `FILL`: no state change.
- **Reset in WAIT:** assert `reset` mid-`WAIT`.
  - Expect outputs at reset values within the same cycle.
  - A following "abc" message must produce the correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder state encoding, block geometry and the initial hash values.
package sha256_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        FILL  = 3'd1,
        PAD   = 3'd2,
        LEN   = 3'd3,
        ISSUE = 3'd4,
        WAIT  = 3'd5,
        FIN   = 3'd6
    } padder_state_t;

    localparam int         BLOCK_WORDS  = 16;
    localparam int         LEN_WORD_IDX = 14;
    localparam logic [7:0] PAD_MARKER   = 8'h80;

    localparam logic [31:0] SHA256_H0 = 32'h6a09e667;
    localparam logic [31:0] SHA256_H1 = 32'hbb67ae85;
    localparam logic [31:0] SHA256_H2 = 32'h3c6ef372;
    localparam logic [31:0] SHA256_H3 = 32'ha54ff53a;
    localparam logic [31:0] SHA256_H4 = 32'h510e527f;
    localparam logic [31:0] SHA256_H5 = 32'h9b05688c;
    localparam logic [31:0] SHA256_H6 = 32'h1f83d9ab;
    localparam logic [31:0] SHA256_H7 = 32'h5be0cd19;

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message front end: packs 32-bit words into 512-bit blocks, appends the marker,
// zero fill and bit length, and sequences the compression core block by block.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic [511:0] blk_data,
    output logic         core_start,
    input  logic         core_done,
    output logic         core_init,
    output logic         msg_done,
    output logic         busy
);

    localparam logic [4:0] IDX_FULL = 5'(BLOCK_WORDS);
    localparam logic [4:0] IDX_LEN  = 5'(LEN_WORD_IDX);

    padder_state_t state;
    padder_state_t post_state;
    logic [31:0]   blk_words [BLOCK_WORDS];
    logic [4:0]    idx;
    logic [LEN_W-1:0] bit_cnt;
    logic          new_msg;
    logic          marker_pending;
    logic          need_len_block;
    logic          final_blk;

    logic [2:0]    k_bytes;
    logic [5:0]    cnt_add;
    logic [31:0]   fill_word;
    logic [31:0]   pad_word;
    logic [LEN_W-1:0] cnt_base;
    logic [LEN_W-1:0] fill_cnt;
    logic [4:0]    idx_inc;
    logic          fill_marker;
    logic          fill_need_len;
    padder_state_t fill_next;
    logic [63:0]   len64;

    always_comb begin
        blk_data = '0;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            blk_data[32*i +: 32] = blk_words[i];
        end
    end

    // Next-step decode for a word accepted in FILL; shared by the first word and the rest.
    always_comb begin
        k_bytes = (in_bytes == 2'd0) ? 3'd4 : {1'b0, in_bytes};
        fill_word = in_data;
        if (in_last) begin
            case (in_bytes)
                2'd1:    fill_word = {in_data[31:24], PAD_MARKER, 16'h0000};
                2'd2:    fill_word = {in_data[31:16], PAD_MARKER, 8'h00};
                2'd3:    fill_word = {in_data[31:8], PAD_MARKER};
                default: fill_word = in_data;
            endcase
        end
        cnt_add       = in_last ? {k_bytes, 3'b000} : 6'd32;
        cnt_base      = new_msg ? '0 : bit_cnt;
        fill_cnt      = cnt_base + LEN_W'(cnt_add);
        idx_inc       = idx + 5'd1;
        fill_marker   = in_last && (in_bytes == 2'd0);
        fill_need_len = 1'b0;
        fill_next     = FILL;
        if (in_last) begin
            if (idx_inc == IDX_FULL) begin
                fill_next     = ISSUE;
                fill_need_len = 1'b1;
            end else if (idx_inc == IDX_LEN && !fill_marker) begin
                fill_next = LEN;
            end else begin
                fill_next = PAD;
            end
        end else if (idx_inc == IDX_FULL) begin
            fill_next = ISSUE;
        end
        pad_word = marker_pending ? {PAD_MARKER, 24'h000000} : 32'h0;
        len64    = 64'(bit_cnt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FILL;
            post_state     <= FILL;
            new_msg        <= 1'b1;
            idx            <= '0;
            bit_cnt        <= '0;
            marker_pending <= 1'b0;
            need_len_block <= 1'b0;
            final_blk      <= 1'b0;
            in_ready       <= 1'b0;
            core_start     <= 1'b0;
            core_init      <= 1'b0;
            msg_done       <= 1'b0;
            busy           <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                blk_words[i] <= '0;
            end
        end else begin
            case (state)
                INIT: begin
                    core_init  <= 1'b0;
                    state      <= post_state;
                    in_ready   <= (post_state == FILL);
                    core_start <= (post_state == ISSUE);
                end
                FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        blk_words[idx[3:0]] <= fill_word;
                        idx            <= idx_inc;
                        bit_cnt        <= fill_cnt;
                        marker_pending <= fill_marker;
                        need_len_block <= fill_need_len;
                        // First word of a message: core reload happens before anything else moves.
                        if (new_msg) begin
                            new_msg    <= 1'b0;
                            busy       <= 1'b1;
                            core_init  <= 1'b1;
                            post_state <= fill_next;
                            state      <= INIT;
                            in_ready   <= 1'b0;
                        end else begin
                            state      <= fill_next;
                            in_ready   <= (fill_next == FILL);
                            core_start <= (fill_next == ISSUE);
                        end
                    end
                end
                PAD: begin
                    if (idx == IDX_LEN && !marker_pending) begin
                        state <= LEN;
                    end else begin
                        blk_words[idx[3:0]] <= pad_word;
                        marker_pending <= 1'b0;
                        idx            <= idx_inc;
                        if (idx_inc == IDX_FULL) begin
                            state          <= ISSUE;
                            need_len_block <= 1'b1;
                            core_start     <= 1'b1;
                        end
                    end
                end
                LEN: begin
                    blk_words[LEN_WORD_IDX]     <= len64[63:32];
                    blk_words[LEN_WORD_IDX + 1] <= len64[31:0];
                    idx        <= IDX_FULL;
                    final_blk  <= 1'b1;
                    state      <= ISSUE;
                    core_start <= 1'b1;
                end
                ISSUE: begin
                    core_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        for (int i = 0; i < BLOCK_WORDS; i++) begin
                            blk_words[i] <= '0;
                        end
                        idx <= '0;
                        if (final_blk) begin
                            final_blk <= 1'b0;
                            msg_done  <= 1'b1;
                            state     <= FIN;
                        end else if (need_len_block) begin
                            need_len_block <= 1'b0;
                            state          <= PAD;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= FILL;
                        end
                    end
                end
                FIN: begin
                    msg_done <= 1'b0;
                    busy     <= 1'b0;
                    new_msg  <= 1'b1;
                    in_ready <= 1'b1;
                    state    <= FILL;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule
